// File: rtl/shreg_piso_if.sv
// Load handshake and serial output bundle for shreg_piso.
interface shreg_piso_if #(
  parameter int unsigned W = 8
);
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         sout;
  logic         sout_valid;
  logic         last;

  // master: the word source and serial sink; slave: the shift register itself
  modport master (
    output load_valid, load_data,
    input  load_ready, sout, sout_valid, last
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, sout, sout_valid, last
  );
endinterface

// File: rtl/shreg_piso.sv
// Parallel-in/serial-out shift register: one W-bit word per frame, gated by
// clock enable e, with back-to-back chaining on the final bit.
module shreg_piso #(
  parameter int unsigned W         = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          NEG_CLK   = 1'b0
) (
  input  logic         clk,
  input  logic         rn,
  input  logic         e,
  shreg_piso_if.slave  bus
);

  localparam int unsigned   CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    SHIFT    = 1'b1;

  logic          aclk;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic          at_last;
  logic          ready;
  logic          accept;

  // Falling-edge build is a plain clock inversion so every flop shares one edge
  assign aclk = NEG_CLK ? ~clk : clk;

  assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign ready   = (state_q == IDLE) || at_last;
  assign accept  = bus.load_valid && ready && e;

  // State register
  always_ff @(posedge aclk or negedge rn) begin
    if (!rn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  // Next state: load wins over shift/retire; e low holds everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    if (e) begin
      if (accept) begin
        state_d = SHIFT;
        cnt_d   = '0;
        sreg_d  = bus.load_data;
      end else if (state_q == SHIFT) begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          sreg_d  = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          sreg_d = MSB_FIRST ? {sreg_q[W-2:0], 1'b0} : {1'b0, sreg_q[W-1:1]};
        end
      end
    end
  end

  assign bus.load_ready = ready;
  assign bus.sout       = MSB_FIRST ? sreg_q[W-1] : sreg_q[0];
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.last       = at_last;

endmodule

// File: tb/tb_shreg_piso.sv
// Bench for shreg_piso: an MSB-first rising-edge copy and an LSB-first
// falling-edge copy share one stimulus stream and are held to a queue model.
module tb_shreg_piso;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rn  = 1'b0;
  logic         e   = 1'b0;
  logic         lv  = 1'b0;
  logic [W-1:0] ld  = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Remaining frame bits in presentation order, front is on sout
  logic q0[$];
  logic q1[$];

  shreg_piso_if #(.W(W)) if0 ();
  shreg_piso_if #(.W(W)) if1 ();

  assign if0.load_valid = lv;
  assign if0.load_data  = ld;
  assign if1.load_valid = lv;
  assign if1.load_data  = ld;

  shreg_piso #(.W(W), .MSB_FIRST(1'b1), .NEG_CLK(1'b0)) u0 (
    .clk(clk), .rn(rn), .e(e), .bus(if0.slave)
  );

  shreg_piso #(.W(W), .MSB_FIRST(1'b0), .NEG_CLK(1'b1)) u1 (
    .clk(clk), .rn(rn), .e(e), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic         v;
    logic [W-1:0] d;
    logic         sout0;
    logic         sout1;
    logic         sv;
    logic         lst;
    logic         rdy;
  } vec_t;

  vec_t tab[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic en, input logic [W-1:0] d);
    if (en) begin
      if (v && q0.size() <= 1) begin
        q0.delete();
        q1.delete();
        for (int i = 0; i < int'(W); i++) begin
          q0.push_back(d[W-1-i]);
          q1.push_back(d[i]);
        end
      end else if (q0.size() > 0) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end
  endtask

  task automatic check_models(input string tag);
    chk({tag, " u0.sout"},  int'(if0.sout),       q0.size() > 0 ? int'(q0[0]) : 0);
    chk({tag, " u0.valid"}, int'(if0.sout_valid), int'(q0.size() > 0));
    chk({tag, " u0.last"},  int'(if0.last),       int'(q0.size() == 1));
    chk({tag, " u0.ready"}, int'(if0.load_ready), int'(q0.size() <= 1));
    chk({tag, " u1.sout"},  int'(if1.sout),       q1.size() > 0 ? int'(q1[0]) : 0);
    chk({tag, " u1.valid"}, int'(if1.sout_valid), int'(q1.size() > 0));
    chk({tag, " u1.last"},  int'(if1.last),       int'(q1.size() == 1));
    chk({tag, " u1.ready"}, int'(if1.load_ready), int'(q1.size() <= 1));
  endtask

  // Drive inputs just after a rising edge; u1 consumes them on the falling
  // edge, u0 on the following rising edge, and both are observed 1 ns later.
  task automatic step(input logic r, input logic en, input logic v, input logic [W-1:0] d);
    rn = r; e = en; lv = v; ld = d;
    @(posedge clk); #1;
    if (!r) begin
      q0.delete();
      q1.delete();
    end else begin
      model_edge(v, en, d);
    end
  endtask

  initial begin
    int vcount;

    //            en    v     d      s0    s1    sv    lst   rdy
    tab[0] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tab[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state, and reset beats a would-be accept
    @(posedge clk); #1;
    check_models("reset");
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    check_models("reset_wins");

    // First accept after release; u1 must move on the falling edge only
    rn = 1'b1; e = 1'b1; lv = 1'b1; ld = 8'h5A;
    @(negedge clk); #1;
    chk("negclk u1.valid mid", int'(if1.sout_valid), 1);
    chk("negclk u0.valid mid", int'(if0.sout_valid), 0);
    @(posedge clk); #1;
    model_edge(1'b1, 1'b1, 8'h5A);
    check_models("edge_load");
    for (int k = 0; k < int'(W); k++) step(1'b1, 1'b1, 1'b0, 8'h00);
    check_models("edge_done");

    // 0xA5 frame from idle, table driven
    chk("a5 ready before", int'(if0.load_ready), 1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, tab[i].en, tab[i].v, tab[i].d);
      chk($sformatf("a5[%0d] u0.sout", i),  int'(if0.sout),       int'(tab[i].sout0));
      chk($sformatf("a5[%0d] u1.sout", i),  int'(if1.sout),       int'(tab[i].sout1));
      chk($sformatf("a5[%0d] valid", i),    int'(if0.sout_valid), int'(tab[i].sv));
      chk($sformatf("a5[%0d] last", i),     int'(if0.last),       int'(tab[i].lst));
      chk($sformatf("a5[%0d] ready", i),    int'(if0.load_ready), int'(tab[i].rdy));
      chk($sformatf("a5[%0d] u1.valid", i), int'(if1.sout_valid), int'(tab[i].sv));
    end

    // Back-to-back 0x01 then 0x80 with load_valid held high
    vcount = 0;
    step(1'b1, 1'b1, 1'b1, 8'h01);
    check_models("b2b");
    if (if1.sout_valid) vcount++;
    for (int k = 0; k < 15; k++) begin
      if (k == 7) begin
        chk("b2b last before 2nd", int'(if1.last), 1);
        chk("b2b ready before 2nd", int'(if1.load_ready), 1);
      end
      step(1'b1, 1'b1, 1'b1, 8'h80);
      check_models("b2b");
      if (if1.sout_valid) vcount++;
    end
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check_models("b2b_end");
    chk("b2b valid bits", vcount, 16);

    // Enable pattern 1,0,0,1 during a 0xC3 frame, including e low on last
    step(1'b1, 1'b1, 1'b1, 8'hC3);
    check_models("ce");
    for (int k = 1; k < 40; k++) begin
      step(1'b1, ((k % 4) == 0) || ((k % 4) == 3), 1'b0, 8'h00);
      check_models("ce");
    end
    step(1'b1, 1'b0, 1'b1, 8'hFF);
    check_models("ce_idle_no_accept");
    step(1'b1, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset mid-frame, then a fresh frame
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check_models("pre_rst");
    #2 rn = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check_models("async_rst");
    step(1'b1, 1'b1, 1'b1, 8'h0F);
    check_models("post_rst");
    for (int k = 0; k < int'(W); k++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      check_models("post_rst");
    end

    // load_data churn mid-frame; only the value at the final bit is taken
    step(1'b1, 1'b1, 1'b1, 8'h3C);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b1, 1'b1, 8'($urandom));
      check_models("churn");
    end
    step(1'b1, 1'b1, 1'b1, 8'h96);
    chk("churn took 0x96 msb", int'(if0.sout), 1);
    chk("churn took 0x96 lsb", int'(if1.sout), 0);
    for (int k = 0; k < int'(W); k++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      check_models("churn_tail");
    end

    // Random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
           1'($urandom), 8'($urandom));
      check_models("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shreg_piso.md
# shreg_piso

Parallel-in/serial-out shift register that drains one W-bit word per frame onto a single-bit serial output. It is the transmit-side counterpart of the serial-in delay-line shift registers in the SRL tests. It accepts words over a valid/ready handshake, advances only on qualified clock edges (clock-enable `e`), and supports back-to-back frames with no idle bit. It is a synthesis-test block: the shift datapath must map to fabric flops with clock enable, not to SRL primitives, because parallel load defeats SRL inference.

## Interface
- `W`, default 8, word width, ≥2.
- `MSB_FIRST`, default 1. 1 shifts bit W-1 out first; 0 shifts bit 0 out first.
- `NEG_CLK`, default 0. 1 makes every flop in the block use the falling edge of `clk`.
- `clk`  in  1  clock; active edge is set by `NEG_CLK`.
- `rn`  in  1  reset, asynchronous, active-low.
- `e`  in  1  clock enable; gates all state updates, including loads.
- `load_valid`  in  1  `load_data` is offered.
- `load_ready`  out  1  block can accept a word on this edge.
- `load_data`  in  W  word to serialize.
- `sout`  out  1  serial data bit.
- `sout_valid`  out  1  `sout` carries a frame bit.
- `last`  out  1  `sout` is the final bit of the current frame.

## Operation
- Two states:
  - IDLE: no frame.
  - SHIFT: a frame is being presented. Counter `cnt` (clog2(W) bits) holds the index of the bit currently on `sout`, 0..W-1.
- `load_ready` = (state == IDLE) | (state == SHIFT & cnt == W-1). It is combinational from state and must not depend on `e` or `load_valid`.
- Accept = `load_valid` & `load_ready` & `e`, sampled on the active edge.
- On accept:
  - shift register ← `load_data`;
  - `cnt` ← 0;
  - state ← SHIFT.
  - This covers both entry from IDLE and back-to-back chaining from the final bit.
- In SHIFT with `e` = 1 and cnt < W-1: the register shifts one position toward the output end (vacated bit filled with 0) and `cnt` increments.
- In SHIFT with `e` = 1, cnt == W-1 and no accept: state ← IDLE and `cnt` ← 0.
- `e` = 0: the entire block holds. Register, `cnt`, state and all outputs are unchanged.
- `load_data` is ignored while `load_ready` = 0. Holding `load_valid` high during a frame has no effect until cnt == W-1.
- Outputs are combinational from registered state only:
  - `sout` = output-end bit of the register (bit W-1 if `MSB_FIRST`, else bit 0);
  - `sout_valid` = (state == SHIFT);
  - `last` = (state == SHIFT & cnt == W-1).
- In IDLE, `sout` = 0. The register is cleared when returning to IDLE.
- `cnt` never exceeds W-1. Wrap to 0 happens only through a load or a return to IDLE.

## Timing
- Reset (`rn` low, at any time, including mid-frame):
  - state = IDLE, `cnt` = 0, register = 0, taking effect immediately;
  - outputs: `sout` = 0, `sout_valid` = 0, `last` = 0, `load_ready` = 1.
  - A partial frame is discarded and is not resumed.
- Reset release: first possible accept is the first active edge with `rn` high.
- Latency: after an accept on edge k, bit 0 of the frame appears on `sout` immediately after edge k. Bit j appears after the j-th subsequent edge with `e` = 1.
- Frame length is exactly W qualified edges. `last` is high for the final bit only.
- Back-to-back: an accept on the edge that ends bit W-1 places bit 0 of the next word on `sout` after that same edge. `sout_valid` stays 1 with no gap bit.
- Simultaneous `rn` assertion and accept: reset wins.
- `e` low while `last` = 1: `last` stays high and `load_ready` stays high until a qualified edge occurs.

## Test plan
- W=8, MSB_FIRST=1, `e`=1, load 0xA5 from IDLE → `sout` = 1,0,1,0,0,1,0,1 over 8 cycles. `sout_valid` is high for exactly 8 cycles. `last` is high on cycle 8 only. `load_ready` = 1 on cycles 0 and 8.
- MSB_FIRST=0, load 0x01 then 0x80 back-to-back, `load_valid` held high → 16 contiguous valid bits: 1,0×7 then 0×7,1. No gap between frames. Second accept occurs on the edge where `last` = 1.
- `e` toggled 1,0,0,1,… during a 0xC3 frame → each bit holds on `sout` while `e` = 0. Sequence is unchanged: 1,1,0,0,0,0,1,1. An accept attempted with `e` = 0 and `load_ready` = 1 is not taken.
- `rn` pulsed low after 3 bits of 0xFF → `sout` = 0, `sout_valid` = 0 and `load_ready` = 1 immediately, asynchronously to `clk`. A new load of 0x0F then yields a fresh full 8-bit frame.
- `load_valid` held high mid-frame with changing `load_data` → the in-progress frame is uncorrupted. Only the value present at cnt == W-1 is taken.
- NEG_CLK=1 repeat of the first test → all transitions occur on the falling edges of `clk`. Post-synth netlist for synth_xilinx contains no SRL16E/SRLC32E cells.
